i4004_fetch: RTL

CPU-side initiator of the MCS-4 instruction bus: generates the 8-phase instruction cycle and `sync`, drives a 12-bit fetch address onto the 4-bit data bus in A1–A3, asserts `cm_rom` to select ROM, and assembles the 8-bit instruction returned by the ROM in M1/M2. It sits between the CPU core's program-counter logic and the shared MCS-4 bus that the ROM chips (i4001 family) respond on. It is the other end of that ROM read protocol.

---
 rtl/mcs4_pkg.sv | 26 ++
 rtl/i4004_fetch_if.sv | 45 ++++
 rtl/mcs4_cyc_gen.sv | 19 +
 rtl/i4004_fetch.sv | 90 +++++++++
 4 files changed

// File: rtl/mcs4_pkg.sv
// Shared MCS-4 bus types: instruction-cycle phase encoding, nibble/byte/address types.
package mcs4;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef logic [3:0]  char_t;
    typedef logic [7:0]  byte_t;
    typedef logic [11:0] rom_addr_t;

    localparam int Cyc_len = 8;

    // X3 wraps to A1 through the natural 3-bit overflow of the encoding.
    function automatic instr_cyc_t next_cyc(input instr_cyc_t c);
        return instr_cyc_t'(c + 3'd1);
    endfunction

endpackage

// File: rtl/i4004_fetch_if.sv
// Fetch handshake and MCS-4 bus bundle for i4004_fetch; X2 transfer ports exist
// only when I4004_FETCH_X2_EN is defined.
interface i4004_fetch_if;
    import mcs4::*;

    // Handshake: the core raises fetch_req with fetch_addr stable and holds both
    // until fetch_ack pulses (always in X3). instr_valid is a one-cycle pulse in X1
    // with no backpressure; instr holds its value until the next pulse.
    logic       fetch_req;
    rom_addr_t  fetch_addr;
    logic       fetch_ack;
    logic       instr_valid;
    byte_t      instr;

    instr_cyc_t icyc;
    logic       sync;
    logic       cm_rom;
    char_t      dbus_in;
    char_t      dbus_out;

`ifdef I4004_FETCH_X2_EN
    logic       x2_drive;
    char_t      x2_data;
    char_t      x2_rdata;

    modport master (
        input  fetch_req, fetch_addr, dbus_in, x2_drive, x2_data,
        output fetch_ack, instr_valid, instr, icyc, sync, cm_rom, dbus_out, x2_rdata
    );
    modport slave (
        output fetch_req, fetch_addr, dbus_in, x2_drive, x2_data,
        input  fetch_ack, instr_valid, instr, icyc, sync, cm_rom, dbus_out, x2_rdata
    );
`else
    modport master (
        input  fetch_req, fetch_addr, dbus_in,
        output fetch_ack, instr_valid, instr, icyc, sync, cm_rom, dbus_out
    );
    modport slave (
        output fetch_req, fetch_addr, dbus_in,
        input  fetch_ack, instr_valid, instr, icyc, sync, cm_rom, dbus_out
    );
`endif

endinterface

// File: rtl/mcs4_cyc_gen.sv
// MCS-4 instruction-cycle phase counter; resets to X2 so the first A1 lands two
// cycles after reset release, with sync decoded in X3.
module mcs4_cyc_gen
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst,
    output instr_cyc_t icyc,
    output logic       sync
);

    always_ff @(posedge clk) begin
        if (rst) icyc <= X2;
        else     icyc <= next_cyc(icyc);
    end

    assign sync = (icyc == X3);

endmodule

// File: rtl/i4004_fetch.sv
// CPU-side MCS-4 ROM fetch initiator: sends a 12-bit address in A1-A3, reads the
// instruction in M1/M2. Optional X2 data transfer enabled by I4004_FETCH_X2_EN.
module i4004_fetch
    import mcs4::*;
(
    input logic         clk,
    input logic         rst,
    i4004_fetch_if.master bus
);

    instr_cyc_t icyc;
    logic       sync;

    logic       ack_q;
    logic       active;
    rom_addr_t  addr_q;
    char_t      opr_q;
    byte_t      instr_q;
    char_t      dbus_q;
    logic       cm_rom_q;

    mcs4_cyc_gen u_cyc_gen (
        .clk  (clk),
        .rst  (rst),
        .icyc (icyc),
        .sync (sync)
    );

    // fetch_req is sampled at the end of X2 so the X3 ack is a registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            active  <= 1'b0;
            addr_q  <= '0;
            opr_q   <= '0;
            instr_q <= '0;
        end else begin
            ack_q <= (icyc == X2) && bus.fetch_req;
            if (icyc == X3) begin
                active <= ack_q;
                if (ack_q) addr_q <= bus.fetch_addr;
            end
            if (active && icyc == M1) opr_q   <= bus.dbus_in;
            if (active && icyc == M2) instr_q <= {opr_q, bus.dbus_in};
        end
    end

    // Bus drive is computed one phase ahead so dbus_out/cm_rom come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbus_q   <= '0;
            cm_rom_q <= 1'b0;
        end else begin
            dbus_q   <= '0;
            cm_rom_q <= 1'b0;
            case (icyc)
                X3: if (ack_q)  dbus_q <= bus.fetch_addr[3:0];
                A1: if (active) dbus_q <= addr_q[7:4];
                A2: if (active) begin
                    dbus_q   <= addr_q[11:8];
                    cm_rom_q <= 1'b1;
                end
`ifdef I4004_FETCH_X2_EN
                X1: if (bus.x2_drive) dbus_q <= bus.x2_data;
`endif
                default: ;
            endcase
        end
    end

`ifdef I4004_FETCH_X2_EN
    char_t x2_rdata_q;

    always_ff @(posedge clk) begin
        if (rst)              x2_rdata_q <= '0;
        else if (icyc == X2)  x2_rdata_q <= bus.dbus_in;
    end

    assign bus.x2_rdata = x2_rdata_q;
`endif

    assign bus.icyc        = icyc;
    assign bus.sync        = sync;
    assign bus.fetch_ack   = ack_q;
    assign bus.instr_valid = active && (icyc == X1);
    assign bus.instr       = instr_q;
    assign bus.dbus_out    = dbus_q;
    assign bus.cm_rom      = cm_rom_q;

endmodule
